// File: rtl/conv_encoder_punct.sv
// Convolutional encoder (default K=7, 133/171 octal) with rate 2/3 and 3/4 puncturing.
// Kept coded bits pass through a two-entry pending buffer using valid/ready handshakes.
module conv_encoder_punct #(
  parameter int             K  = 7,
  parameter logic [K-1:0]   G0 = 7'o133,
  parameter logic [K-1:0]   G1 = 7'o171
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Rate,
  input  logic       Input,
  input  logic       InValid,
  output logic       InReady,
  output logic       Output,
  output logic       OutValid,
  input  logic       OutReady
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_e;

  state_e       state_q, state_d;
  logic [K-2:0] sr_q, sr_d;
  logic [1:0]   phase_q, phase_d;
  logic [1:0]   rate_q, rate_d;
  logic [1:0]   pend_q, pend_d;

  logic [K-1:0] full;
  logic         codeA, codeB;
  logic         keepA, keepB, phaseLast;
  logic         inXfer, outXfer;

  assign full    = {Input, sr_q};
  assign codeA   = ^(G0 & full);
  assign codeB   = ^(G1 & full);
  assign inXfer  = InValid & InReady;
  assign outXfer = OutValid & OutReady;

  // Rate code 11 falls into the default branch and therefore behaves as rate 1/2.
  always_comb begin
    keepA     = 1'b1;
    keepB     = 1'b1;
    phaseLast = 1'b1;
    case (rate_q)
      2'b01: begin
        phaseLast = (phase_q == 2'd1);
        if (phase_q == 2'd1) keepB = 1'b0;
      end
      2'b10: begin
        phaseLast = (phase_q == 2'd2);
        if (phase_q == 2'd1) keepB = 1'b0;
        if (phase_q == 2'd2) keepA = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      phase_q <= '0;
      rate_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      phase_q <= phase_d;
      rate_q  <= rate_d;
      pend_q  <= pend_d;
    end
  end

  // The state encodes how many coded bits are waiting; Start flushes them unsent.
  always_comb begin
    state_d = state_q;
    if (Start) begin
      state_d = IDLE;
    end else if (inXfer) begin
      state_d = (keepA && keepB) ? EMIT2 : EMIT1;
    end else if (outXfer) begin
      state_d = (state_q == EMIT2) ? EMIT1 : IDLE;
    end
  end

  always_comb begin
    OutValid = 1'b0;
    Output   = 1'b0;
    InReady  = 1'b0;
    if (Reset && !Start) begin
      OutValid = (state_q != IDLE);
      Output   = (state_q != IDLE) ? pend_q[0] : 1'b0;
      InReady  = (state_q == IDLE) || ((state_q == EMIT1) && OutReady);
    end
  end

  // New bits only load once the buffer is empty after any departure, so they overwrite it.
  always_comb begin
    sr_d    = sr_q;
    phase_d = phase_q;
    rate_d  = rate_q;
    pend_d  = pend_q;
    if (Start) begin
      sr_d    = '0;
      phase_d = '0;
      rate_d  = Rate;
      pend_d  = '0;
    end else begin
      if (outXfer) begin
        pend_d = {1'b0, pend_q[1]};
      end
      if (inXfer) begin
        sr_d    = {Input, sr_q[K-2:1]};
        phase_d = phaseLast ? 2'd0 : phase_q + 2'd1;
        pend_d  = keepA ? {codeB, codeA} : {1'b0, codeB};
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Directed bench for conv_encoder_punct: hand-computed impulse responses per code rate,
// backpressure, Start abort and asynchronous reset behaviour.
module tb_conv_encoder_punct;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic [1:0] Rate;
  logic       Input;
  logic       InValid;
  logic       InReady;
  logic       Output;
  logic       OutValid;
  logic       OutReady;

  int   total = 0;
  int   bad   = 0;
  logic outQ[$];

  conv_encoder_punct dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Rate     (Rate),
    .Input    (Input),
    .InValid  (InValid),
    .InReady  (InReady),
    .Output   (Output),
    .OutValid (OutValid),
    .OutReady (OutReady)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Every output handshake appends the coded bit to the captured stream.
  always @(posedge Clock) begin
    if (OutValid && OutReady) outQ.push_back(Output);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [1:0] rate, input logic outReady);
    Start    = start;
    Rate     = rate;
    OutReady = outReady;
  endtask

  // A bit offered together with Start must be dropped; the checks confirm both handshakes are blocked.
  task automatic startFrame(input logic [1:0] rate, input logic outReady, input string tag);
    applyStimulus(1'b1, rate, outReady);
    Input   = 1'b1;
    InValid = 1'b1;
    @(negedge Clock);
    checkOutput({tag, "_start_inready"}, 32'(InReady), 32'd0);
    checkOutput({tag, "_start_outvalid"}, 32'(OutValid), 32'd0);
    stepClk();
    InValid = 1'b0;
    Input   = 1'b0;
    applyStimulus(1'b0, 2'b00, outReady);
  endtask

  task automatic sendBit(input logic b, input string tag);
    int guard;
    guard   = 0;
    Input   = b;
    InValid = 1'b1;
    @(negedge Clock);
    while (!InReady && guard < 64) begin
      stepClk();
      @(negedge Clock);
      guard++;
    end
    checkOutput({tag, "_accept"}, 32'(guard < 64), 32'd1);
    stepClk();
    InValid = 1'b0;
    Input   = 1'b0;
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) sendBit(bits[i], tag);
  endtask

  // Waits for n coded bits, lingers to expose extras, then compares length and content.
  task automatic checkStream(input string tag, input logic [31:0] expected, input int n);
    int          guard;
    logic [31:0] got;
    guard = 0;
    while (outQ.size() < n && guard < 100) begin
      stepClk();
      guard++;
    end
    checkOutput({tag, "_timeout"}, 32'(guard < 100), 32'd1);
    repeat (3) stepClk();
    checkOutput({tag, "_len"}, 32'(outQ.size()), 32'(n));
    got = '0;
    for (int i = 0; i < outQ.size() && i < 32; i++) got = {got[30:0], outQ[i]};
    checkOutput({tag, "_bits"}, got, expected);
    outQ.delete();
  endtask

  initial begin
    Reset = 1'b0;
    Input = 1'b0;
    InValid = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b1);

    #2;
    checkOutput("rst_inready", 32'(InReady), 32'd0);
    checkOutput("rst_outvalid", 32'(OutValid), 32'd0);
    checkOutput("rst_output", 32'(Output), 32'd0);
    #10 Reset = 1'b1;
    @(negedge Clock);
    checkOutput("post_rst_inready", 32'(InReady), 32'd1);
    stepClk();

    // No Start after reset: encoder runs at rate 1/2 from a clean register.
    sendBits(16'b10, 2, "norate");
    checkStream("norate", 32'b1101, 4);

    startFrame(2'b00, 1'b1, "r12");
    sendBits(16'b1000000, 7, "r12");
    checkStream("r12", 32'b11011111001011, 14);

    startFrame(2'b01, 1'b1, "r23");
    sendBits(16'b100, 3, "r23");
    checkStream("r23", 32'b11011, 5);

    startFrame(2'b11, 1'b1, "r11");
    sendBits(16'b10, 2, "r11");
    checkStream("r11", 32'b1101, 4);

    startFrame(2'b10, 1'b1, "r34");
    sendBits(16'b100, 3, "r34");
    checkStream("r34", 32'b1101, 4);

    startFrame(2'b00, 1'b0, "hold");
    sendBit(1'b1, "hold");
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      checkOutput($sformatf("hold%0d_outvalid", c), 32'(OutValid), 32'd1);
      checkOutput($sformatf("hold%0d_output", c), 32'(Output), 32'd1);
      checkOutput($sformatf("hold%0d_inready", c), 32'(InReady), 32'd0);
      stepClk();
    end
    OutReady = 1'b1;
    sendBits(16'b000000, 6, "hold");
    checkStream("hold", 32'b11011111001011, 14);

    startFrame(2'b10, 1'b1, "abort");
    sendBits(16'b10, 2, "abort");
    OutReady = 1'b0;
    @(negedge Clock);
    checkOutput("abort_pending", 32'(OutValid), 32'd1);
    stepClk();
    outQ.delete();
    startFrame(2'b10, 1'b1, "abort2");
    repeat (4) stepClk();
    checkOutput("abort_residual", 32'(outQ.size()), 32'd0);
    sendBits(16'b100, 3, "abort");
    checkStream("abort", 32'b1101, 4);

    startFrame(2'b00, 1'b0, "arst");
    sendBit(1'b1, "arst");
    checkOutput("arst_before", 32'(OutValid), 32'd1);
    #2 Reset = 1'b0;
    #1;
    checkOutput("arst_outvalid", 32'(OutValid), 32'd0);
    checkOutput("arst_output", 32'(Output), 32'd0);
    checkOutput("arst_inready", 32'(InReady), 32'd0);
    stepClk();
    Reset = 1'b0;
    #3 Reset = 1'b1;
    stepClk();
    OutReady = 1'b1;
    outQ.delete();
    sendBits(16'b1000000, 7, "arst");
    checkStream("arst", 32'b11011111001011, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
